// File: rtl/any1_pkg.sv
// Shared ANY-1 memory-access types: access size, response-sequencer states
// and byte-lane helpers for the 64-bit data bus.
package any1_pkg;

    localparam int BUS_BYTES = 8;

    typedef enum logic [1:0] {
        BYT   = 2'd0,
        WYDE  = 2'd1,
        TETRA = 2'd2,
        OCTA  = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        MR_IDLE = 2'd0,
        MR_ACC1 = 2'd1,
        MR_ACC2 = 2'd2,
        MR_DONE = 2'd3
    } mem_rsp_state_e;

    // Byte enables across two consecutive bus words; the upper half is the second access.
    function automatic logic [2*BUS_BYTES-1:0] lane_mask(input logic [1:0] sz, input logic [2:0] off);
        logic [BUS_BYTES-1:0] base;
        case (mem_size_e'(sz))
            BYT:     base = 8'h01;
            WYDE:    base = 8'h03;
            TETRA:   base = 8'h0F;
            OCTA:    base = 8'hFF;
            default: base = 8'hFF;
        endcase
        return {8'h00, base} << off;
    endfunction

    function automatic logic [2*64-1:0] lane_data(input logic [63:0] dat, input logic [2:0] off);
        return {64'h0, dat} << {off, 3'b000};
    endfunction

endpackage

// File: rtl/any1_mem_align.sv
// Load-data merge and alignment: shifts the two-word read window down to the
// addressed byte and sign- or zero-extends to 64 bits.
module any1_mem_align
    import any1_pkg::*;
(
    input  logic [127:0] data_i,
    input  logic [2:0]   off_i,
    input  logic [1:0]   sz_i,
    input  logic         sgn_i,
    output logic [63:0]  res_o
);

    logic [63:0] win_s;

    assign win_s = 64'(data_i >> {off_i, 3'b000});

    // Truncate to the access size, then extend.
    always_comb begin
        res_o = win_s;
        case (mem_size_e'(sz_i))
            BYT:     res_o = {{56{sgn_i & win_s[7]}}, win_s[7:0]};
            WYDE:    res_o = {{48{sgn_i & win_s[15]}}, win_s[15:0]};
            TETRA:   res_o = {{32{sgn_i & win_s[31]}}, win_s[31:0]};
            OCTA:    res_o = win_s;
            default: res_o = win_s;
        endcase
    end

endmodule

// File: rtl/any1_mem_rsp.sv
// ANY-1 memory-access sequencer: one or two locked bus cycles per request,
// load merge/extend, one-cycle done pulse. Optional watchdog: ANY1_MEM_RSP_TIMEOUT_EN.
module any1_mem_rsp
    import any1_pkg::*;
#(
    parameter int AWID       = 32,
    parameter int TMO_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_i,
    output logic            rdy_o,
    input  logic            ld_i,
    input  logic [1:0]      sz_i,
    input  logic            sgn_i,
    input  logic [AWID-1:0] ea_i,
    input  logic [63:0]     sdat_i,
    output logic            done_o,
    output logic            err_o,
    output logic [63:0]     res_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [7:0]      sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [63:0]     dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [63:0]     dat_i
);

    mem_rsp_state_e state_q, state_d;

    logic            ld_q, ld_d, sgn_q, sgn_d;
    logic [1:0]      sz_q, sz_d;
    logic [AWID-1:0] ea_q, ea_d;
    logic [63:0]     sdat_q, sdat_d;
    logic [63:0]     lo_q, lo_d, hi_q, hi_d;

    logic            rdy_q, rdy_d, done_q, done_d, err_q, err_d;
    logic [63:0]     res_q, res_d;
    logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [7:0]      sel_q, sel_d;
    logic [AWID-1:0] adr_q, adr_d;
    logic [63:0]     dat_q, dat_d;

    logic [15:0]     mask_in_s, mask_s;
    logic [127:0]    lane_in_s, lane_s;
    logic [AWID-1:0] adr2_s;
    logic [63:0]     align_res_s;
    logic            tmo_hit_s, go_done_s, go_err_s;

    assign mask_in_s = lane_mask(sz_i, ea_i[2:0]);
    assign lane_in_s = lane_data(sdat_i, ea_i[2:0]);
    assign mask_s    = lane_mask(sz_q, ea_q[2:0]);
    assign lane_s    = lane_data(sdat_q, ea_q[2:0]);
    // Second word address wraps at the top of the address space.
    assign adr2_s    = {ea_q[AWID-1:3] + {{(AWID-4){1'b0}}, 1'b1}, 3'b000};

    any1_mem_align u_align (
        .data_i ({hi_d, lo_d}),
        .off_i  (ea_q[2:0]),
        .sz_i   (sz_q),
        .sgn_i  (sgn_q),
        .res_o  (align_res_s)
    );

`ifdef ANY1_MEM_RSP_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
    logic [15:0] tmo_q;

    assign tmo_hit_s = (tmo_q == TMO_LAST) && !ack_i && !err_i;

    // Watchdog counts strobed cycles without a bus response.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 16'd0;
        end else if ((state_q == MR_ACC1 || state_q == MR_ACC2) && !ack_i && !err_i) begin
            tmo_q <= tmo_q + 16'd1;
        end else begin
            tmo_q <= 16'd0;
        end
    end
`else
    logic unused_tmo_s;
    assign unused_tmo_s = ^32'(TMO_CYCLES);
    assign tmo_hit_s    = 1'b0;
`endif

    // Next-state, request capture and registered bus/result outputs.
    always_comb begin
        state_d   = state_q;
        ld_d      = ld_q;
        sz_d      = sz_q;
        sgn_d     = sgn_q;
        ea_d      = ea_q;
        sdat_d    = sdat_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        res_d     = 64'h0;
        go_done_s = 1'b0;
        go_err_s  = 1'b0;

        case (state_q)
            MR_IDLE: begin
                if (req_i) begin
                    ld_d    = ld_i;
                    sz_d    = sz_i;
                    sgn_d   = sgn_i;
                    ea_d    = ea_i;
                    sdat_d  = sdat_i;
                    lo_d    = 64'h0;
                    hi_d    = 64'h0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = ~ld_i;
                    sel_d   = mask_in_s[7:0];
                    adr_d   = {ea_i[AWID-1:3], 3'b000};
                    dat_d   = lane_in_s[63:0];
                    state_d = MR_ACC1;
                end else begin
                    state_d = MR_IDLE;
                end
            end
            MR_ACC1: begin
                if (err_i || tmo_hit_s) begin
                    go_done_s = 1'b1;
                    go_err_s  = 1'b1;
                end else if (ack_i) begin
                    lo_d = dat_i;
                    if (mask_s[15:8] != 8'h00) begin
                        sel_d   = mask_s[15:8];
                        adr_d   = adr2_s;
                        dat_d   = lane_s[127:64];
                        state_d = MR_ACC2;
                    end else begin
                        go_done_s = 1'b1;
                    end
                end else begin
                    state_d = MR_ACC1;
                end
            end
            MR_ACC2: begin
                if (err_i || tmo_hit_s) begin
                    go_done_s = 1'b1;
                    go_err_s  = 1'b1;
                end else if (ack_i) begin
                    hi_d      = dat_i;
                    go_done_s = 1'b1;
                end else begin
                    state_d = MR_ACC2;
                end
            end
            MR_DONE: begin
                state_d = MR_IDLE;
            end
            default: begin
                state_d = MR_IDLE;
            end
        endcase

        if (go_done_s) begin
            state_d = MR_DONE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = 8'h00;
            adr_d   = '0;
            dat_d   = 64'h0;
            done_d  = 1'b1;
            err_d   = go_err_s;
            res_d   = (go_err_s || !ld_q) ? 64'h0 : align_res_s;
        end else begin
            done_d  = 1'b0;
        end

        rdy_d = (state_d == MR_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MR_IDLE;
            ld_q    <= 1'b0;
            sz_q    <= 2'd0;
            sgn_q   <= 1'b0;
            ea_q    <= '0;
            sdat_q  <= 64'h0;
            lo_q    <= 64'h0;
            hi_q    <= 64'h0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= 64'h0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 8'h00;
            adr_q   <= '0;
            dat_q   <= 64'h0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            sz_q    <= sz_d;
            sgn_q   <= sgn_d;
            ea_q    <= ea_d;
            sdat_q  <= sdat_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            res_q   <= res_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    assign rdy_o  = rdy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign res_o  = res_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = stb_q;
    assign we_o   = we_q;
    assign sel_o  = sel_q;
    assign adr_o  = adr_q;
    assign dat_o  = dat_q;

endmodule

// File: tb/tb_any1_mem_rsp.sv
// Scoreboard bench for any1_mem_rsp: a bus-slave model checks every strobed
// beat against queued expectations; a monitor checks every done pulse.
module tb_any1_mem_rsp;

    typedef struct {
        logic [31:0] adr;
        logic [7:0]  sel;
        logic [63:0] dat;
        logic        we;
        logic [63:0] rdata;
        logic        err;
        int          wait_n;
        bit          noack;
        bit          seen;
    } beat_t;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
        int          req_cyc;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, ld_i, sgn_i;
    logic [1:0]  sz_i;
    logic [31:0] ea_i;
    logic [63:0] sdat_i;
    logic        rdy_o, done_o, err_o, cyc_o, stb_o, we_o;
    logic [63:0] res_o, dat_o, dat_i;
    logic [7:0]  sel_o;
    logic [31:0] adr_o;
    logic        ack_i, slv_ack, slv_err, force_ack;

    beat_t slv_q[$];
    rsp_t  rsp_q[$];
    int    n_chk = 0, n_fail = 0, cyc_n = 0, done_cnt = 0, cyc_rise = 0;
    logic  cyc_prev = 1'b0;

    assign ack_i = slv_ack | force_ack;

    any1_mem_rsp #(.AWID(32), .TMO_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .rdy_o(rdy_o), .ld_i(ld_i),
        .sz_i(sz_i), .sgn_i(sgn_i), .ea_i(ea_i), .sdat_i(sdat_i),
        .done_o(done_o), .err_o(err_o), .res_o(res_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
        .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .err_i(slv_err), .dat_i(dat_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // Bus slave and completion monitor, both sampled on the falling edge.
    always @(negedge clk) begin
        rsp_t r;
        slv_ack = 1'b0;
        slv_err = 1'b0;
        dat_i   = 64'h0;
        if (rst) begin
            slv_q.delete();
            rsp_q.delete();
            cyc_rise = 0;
        end else begin
            if (cyc_o && !cyc_prev) cyc_rise++;
            if (done_o) begin
                done_cnt++;
                if (rsp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexp_done: got res 0x%h err %0b, want no completion", res_o, err_o);
                end else begin
                    r = rsp_q.pop_front();
                    check("res", res_o, r.res);
                    check("err", 64'(err_o), 64'(r.err));
                    if (r.lat >= 0) check("latency", 64'(cyc_n - r.req_cyc), 64'(r.lat));
                    check("cyc_locked", 64'(cyc_rise), 64'd1);
                end
                cyc_rise = 0;
            end
            if (stb_o) begin
                if (slv_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexp_stb: got strobe at adr 0x%h, want none", adr_o);
                end else begin
                    if (!slv_q[0].seen) begin
                        check("adr", 64'(adr_o), 64'(slv_q[0].adr));
                        check("sel", 64'(sel_o), 64'(slv_q[0].sel));
                        check("dat_o", dat_o, slv_q[0].dat);
                        check("we", 64'(we_o), 64'(slv_q[0].we));
                        check("cyc_with_stb", 64'(cyc_o), 64'd1);
                        slv_q[0].seen = 1'b1;
                    end
                    if (slv_q[0].noack) begin
                        slv_ack = 1'b0;
                    end else if (slv_q[0].wait_n > 0) begin
                        slv_q[0].wait_n--;
                    end else begin
                        slv_ack = ~slv_q[0].err;
                        slv_err = slv_q[0].err;
                        dat_i   = slv_q[0].rdata;
                        void'(slv_q.pop_front());
                    end
                end
            end else if (done_o && slv_q.size() > 0 && slv_q[0].noack) begin
                void'(slv_q.pop_front());
            end
        end
        cyc_prev = cyc_o;
    end

    task automatic beat(input logic [31:0] adr, input logic [7:0] sel, input logic [63:0] dat,
                        input logic we, input logic [63:0] rdata, input logic err,
                        input int wait_n, input bit noack);
        beat_t b;
        b.adr = adr; b.sel = sel; b.dat = dat; b.we = we; b.rdata = rdata;
        b.err = err; b.wait_n = wait_n; b.noack = noack; b.seen = 1'b0;
        slv_q.push_back(b);
    endtask

    task automatic send(input logic ld, input logic [1:0] sz, input logic sgn, input logic [31:0] ea,
                        input logic [63:0] sd, input bit exp_done, input logic [63:0] exp_res,
                        input logic exp_err, input int lat);
        rsp_t r;
        int g;
        g = 0;
        @(negedge clk);
        while (!rdy_o && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!rdy_o) begin
            n_chk++;
            n_fail++;
            $display("FAIL rdy_timeout: got rdy_o 0, want 1");
        end else begin
            if (exp_done) begin
                r.res = exp_res; r.err = exp_err; r.lat = lat; r.req_cyc = cyc_n;
                rsp_q.push_back(r);
            end
            ld_i = ld; sz_i = sz; sgn_i = sgn; ea_i = ea; sdat_i = sd; req_i = 1'b1;
            @(negedge clk);
            req_i = 1'b0;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int i;
        i = 0;
        while (rsp_q.size() != 0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        if (rsp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending completions, want 0", rsp_q.size());
            pulse_rst();
        end
    endtask

    initial begin
        int saved;
        rst = 1'b1; req_i = 1'b0; ld_i = 1'b0; sz_i = 2'd0; sgn_i = 1'b0;
        ea_i = 32'h0; sdat_i = 64'h0; force_ack = 1'b0;
        slv_ack = 1'b0; slv_err = 1'b0; dat_i = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 64'(rdy_o), 64'd1);
        check("rst_cyc_stb_we", {61'h0, cyc_o, stb_o, we_o}, 64'd0);
        check("rst_sel_adr", {24'h0, sel_o, adr_o}, 64'd0);
        check("rst_dat", dat_o, 64'h0);
        check("rst_done_err", {62'h0, done_o, err_o}, 64'd0);
        check("rst_res", res_o, 64'h0);
        rst = 1'b0;

        // Aligned octa load, immediate ack.
        beat(32'h1000, 8'hFF, 64'h0, 1'b0, 64'h1122334455667788, 1'b0, 0, 1'b0);
        send(1'b1, 2'd3, 1'b0, 32'h1000, 64'h0, 1'b1, 64'h1122334455667788, 1'b0, 2);
        wait_done(20);

        // Byte load at offset 3, signed then unsigned, with a wait state.
        beat(32'h1000, 8'h08, 64'h0, 1'b0, 64'h0000000080000000, 1'b0, 1, 1'b0);
        send(1'b1, 2'd0, 1'b1, 32'h1003, 64'h0, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0, -1);
        wait_done(20);
        beat(32'h1000, 8'h08, 64'h0, 1'b0, 64'h0000000080000000, 1'b0, 1, 1'b0);
        send(1'b1, 2'd0, 1'b0, 32'h1003, 64'h0, 1'b1, 64'h0000000000000080, 1'b0, -1);
        wait_done(20);

        // Signed wyde load at offset 2.
        beat(32'h2000, 8'h0C, 64'h0, 1'b0, 64'h0000000080010000, 1'b0, 0, 1'b0);
        send(1'b1, 2'd1, 1'b1, 32'h2002, 64'h0, 1'b1, 64'hFFFFFFFFFFFF8001, 1'b0, 2);
        wait_done(20);

        // Split tetra store across an 8-byte boundary.
        beat(32'h1008, 8'hC0, 64'hCCDD000000000000, 1'b1, 64'h0, 1'b0, 0, 1'b0);
        beat(32'h1010, 8'h03, 64'h000000000000AABB, 1'b1, 64'h0, 1'b0, 0, 1'b0);
        send(1'b0, 2'd2, 1'b0, 32'h100E, 64'h00000000AABBCCDD, 1'b1, 64'h0, 1'b0, 3);
        wait_done(20);

        // Split wyde load wrapping the address space.
        beat(32'hFFFFFFF8, 8'h80, 64'h0, 1'b0, 64'hAB00000000000000, 1'b0, 0, 1'b0);
        beat(32'h00000000, 8'h01, 64'h0, 1'b0, 64'h00000000000000CD, 1'b0, 2, 1'b0);
        send(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 64'h0, 1'b1, 64'h000000000000CDAB, 1'b0, -1);
        wait_done(20);

        // Bus error on the first half of a split load: no second strobe.
        beat(32'hFFFFFFF8, 8'h80, 64'h0, 1'b0, 64'hAB00000000000000, 1'b1, 0, 1'b0);
        send(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 64'h0, 1'b1, 64'h0, 1'b1, 2);
        wait_done(20);
        repeat (3) @(negedge clk);

        // Reset during ACC1, then a late ack that must be ignored.
        saved = done_cnt;
        beat(32'h3000, 8'hFF, 64'h0, 1'b0, 64'h0, 1'b0, 0, 1'b1);
        send(1'b1, 2'd3, 1'b0, 32'h3000, 64'h0, 1'b0, 64'h0, 1'b0, -1);
        @(negedge clk);
        check("acc1_stb", 64'(stb_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cyc_stb", {62'h0, cyc_o, stb_o}, 64'd0);
        check("mid_rst_rdy", 64'(rdy_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt), 64'(saved));
        check("late_ack_idle", {62'h0, cyc_o, rdy_o}, 64'd1);

`ifdef ANY1_MEM_RSP_TIMEOUT_EN
        // Watchdog terminates an unanswered access after 255 strobed cycles.
        beat(32'h4000, 8'hFF, 64'h0, 1'b0, 64'h0, 1'b0, 0, 1'b1);
        send(1'b1, 2'd3, 1'b0, 32'h4000, 64'h0, 1'b1, 64'h0, 1'b1, 256);
        wait_done(600);
`else
        // Without a watchdog the access waits indefinitely.
        saved = done_cnt;
        beat(32'h4000, 8'hFF, 64'h0, 1'b0, 64'h0, 1'b0, 0, 1'b1);
        send(1'b1, 2'd3, 1'b0, 32'h4000, 64'h0, 1'b0, 64'h0, 1'b0, -1);
        repeat (1000) @(negedge clk);
        check("hang_cyc_stb", {62'h0, cyc_o, stb_o}, 64'd3);
        check("hang_rdy", 64'(rdy_o), 64'd0);
        check("hang_no_done", 64'(done_cnt), 64'(saved));
        pulse_rst();
`endif

        repeat (3) @(negedge clk);
        check("beats_left", 64'(slv_q.size()), 64'd0);
        check("rsp_left", 64'(rsp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
